// File: rtl/pla_sweep_pkg.sv
// rtl/pla_sweep_pkg.sv - shared types and sizes for the PLA sweep sequencer
package pla_sweep_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/pla_settle_counter.sv
// rtl/pla_settle_counter.sv - per-vector settle timer with terminal-count flag
module pla_settle_counter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [3:0] TERMINAL = 4'(SETTLE_CYCLES - 1);

    logic [3:0] settle_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (clear) begin
            settle_cnt <= '0;
        end else if (enable) begin
            settle_cnt <= settle_cnt + 4'd1;
        end
    end

    // Gated by enable so a held cycle on the terminal count does not advance the FSM.
    assign expired = enable && (settle_cnt == TERMINAL);

endmodule

// File: rtl/pla_sweep_sequencer.sv
// rtl/pla_sweep_sequencer.sv - exhaustive 16-vector PLA sweep driver and truth-table collector
import pla_sweep_pkg::*;

module pla_sweep_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hold,
    input  logic        y_in,
    input  logic        z_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic [15:0] y_table,
    output logic [15:0] z_table,
    output logic [4:0]  overlap_cnt,
    output logic        busy,
    output logic        done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] index;
    logic             begin_sweep;
    logic             capture;
    logic             settle_clear;
    logic             settle_en;
    logic             settle_expired;

    pla_settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (settle_clear),
        .enable (settle_en),
        .expired(settle_expired)
    );

    // Counter sits at zero outside SETTLE, so every entry into SETTLE starts fresh.
    assign settle_clear = (state != ST_SETTLE);
    assign settle_en    = (state == ST_SETTLE) && !hold;

    always_comb begin
        state_nxt   = state;
        begin_sweep = 1'b0;
        capture     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    begin_sweep = 1'b1;
                    state_nxt   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_expired) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (!hold) begin
                    capture   = 1'b1;
                    state_nxt = (index == LAST_IDX) ? ST_DONE : ST_SETTLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            index       <= '0;
            y_table     <= '0;
            z_table     <= '0;
            overlap_cnt <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);
            done  <= (state_nxt == ST_DONE);
            if (begin_sweep) begin
                index       <= '0;
                y_table     <= '0;
                z_table     <= '0;
                overlap_cnt <= '0;
            end else if (capture) begin
                y_table[index] <= y_in;
                z_table[index] <= z_in;
                if (y_in && z_in) begin
                    overlap_cnt <= overlap_cnt + CNT_W'(1);
                end
                // Index parks on the last vector so DONE keeps driving 1111.
                if (index != LAST_IDX) begin
                    index <= index + IDX_W'(1);
                end
            end
        end
    end

    assign {a, b, c, d} = index;

endmodule

// File: tb/tb_pla_sweep_sequencer.sv
// tb/tb_pla_sweep_sequencer.sv - scoreboard bench for pla_sweep_sequencer at two settle lengths
module tb_pla_sweep_sequencer;

    typedef struct {
        logic [15:0] y;
        logic [15:0] z;
        int          ov;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        hold;
    logic [15:0] ymask;
    logic [15:0] zmask;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;

    logic [3:0]  abcd_w [2];
    logic [15:0] yt_w   [2];
    logic [15:0] zt_w   [2];
    logic [4:0]  ov_w   [2];
    logic        busy_w [2];
    logic        done_w [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int popc(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic check(input string name, input int dut, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, dut, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : 3;

        logic        a, b, c, d, y_in, z_in, busy, done;
        logic [15:0] y_table, z_table;
        logic [4:0]  overlap_cnt;

        // PLA stand-in: truth tables chosen by the stimulus.
        assign y_in = ymask[{a, b, c, d}];
        assign z_in = zmask[{a, b, c, d}];

        pla_sweep_sequencer #(.SETTLE_CYCLES(S)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
            .y_in(y_in), .z_in(z_in), .a(a), .b(b), .c(c), .d(d),
            .y_table(y_table), .z_table(z_table), .overlap_cnt(overlap_cnt),
            .busy(busy), .done(done)
        );

        assign abcd_w[g] = {a, b, c, d};
        assign yt_w[g]   = y_table;
        assign zt_w[g]   = z_table;
        assign ov_w[g]   = overlap_cnt;
        assign busy_w[g] = busy;
        assign done_w[g] = done;

        // Reference: a sweep needs 16*(S+1) unheld busy cycles; results are the PLA tables themselves.
        exp_t        q[$];
        exp_t        e;
        bit          active = 1'b0;
        int          left, el, c0;
        logic [15:0] ey, ez;

        always @(posedge clk) begin
            if (!rst_n) begin
                active = 1'b0;
                q.delete();
            end else if (!active) begin
                if (start) begin
                    active = 1'b1;
                    left   = 16 * (S + 1);
                    el     = 0;
                    c0     = cyc;
                    ey     = ymask;
                    ez     = zmask;
                end
            end else begin
                el++;
                if (!hold) left--;
                if (left == 0) begin
                    active = 1'b0;
                    q.push_back('{ey, ez, popc(ey & ez), c0 + el + 1});
                end
            end
        end

        logic       prev_done = 1'b0;
        logic       prev_busy = 1'b0;
        logic [3:0] prev_abcd = 4'd0;

        always @(negedge clk) begin
            if (busy && !prev_busy)
                check("first_index", g, 32'(abcd_w[g]), 32'd0);
            else if (busy && abcd_w[g] != prev_abcd)
                check("index_step", g, 32'(abcd_w[g]), 32'(prev_abcd) + 32'd1);
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", g, 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("y_table", g, 32'(y_table), 32'(e.y));
                    check("z_table", g, 32'(z_table), 32'(e.z));
                    check("overlap_cnt", g, 32'(overlap_cnt), e.ov);
                    check("done_cycle", g, cyc, e.cyc);
                    check("done_abcd", g, 32'(abcd_w[g]), 32'hF);
                    check("done_busy", g, 32'(busy), 32'd0);
                end
            end
            prev_done = done;
            prev_busy = busy;
            prev_abcd = abcd_w[g];
        end
    end

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_abcd"}, i, 32'(abcd_w[i]), 32'd0);
            check({tag, "_ytab"}, i, 32'(yt_w[i]), 32'd0);
            check({tag, "_ztab"}, i, 32'(zt_w[i]), 32'd0);
            check({tag, "_ovl"},  i, 32'(ov_w[i]), 32'd0);
            check({tag, "_busy"}, i, 32'(busy_w[i]), 32'd0);
            check({tag, "_done"}, i, 32'(done_w[i]), 32'd0);
        end
    endtask

    // hold_mode: 0 none, 1 fixed window plus a SAMPLE pulse, 2 random.
    task automatic run_sweep(input int hold_mode, input bit noise);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 1; j < 600; j++) begin
            hold = 1'b0;
            if (hold_mode == 1) hold = (j >= 13 && j <= 16) || (j == 24);
            else if (hold_mode == 2) hold = ($urandom_range(3) == 0);
            start = (noise && j < 30) ? ($urandom_range(2) == 0) : 1'b0;
            @(posedge clk); #1;
            if (!g_dut[0].active && !g_dut[1].active) break;
        end
        hold  = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_seen", 0, g_dut[0].q.size(), 0);
        check("done_seen", 1, g_dut[1].q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        ymask = 16'h0000;
        zmask = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        ymask = 16'h8801;
        zmask = 16'h4020;
        run_sweep(0, 1'b0);
        check("plan_y", 0, 32'(yt_w[0]), 32'h8801);
        check("plan_z", 0, 32'(zt_w[0]), 32'h4020);
        check("plan_ov", 0, 32'(ov_w[0]), 32'd0);

        zmask = 16'hFFFF;
        run_sweep(0, 1'b0);
        check("zforce_z", 1, 32'(zt_w[1]), 32'hFFFF);
        check("zforce_ov", 1, 32'(ov_w[1]), 32'd3);

        zmask = 16'h4020;
        run_sweep(1, 1'b0);
        run_sweep(0, 1'b1);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("pre_reset_index", 0, 32'(abcd_w[0]), 32'd9);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        #1;
        run_sweep(0, 1'b0);

        ymask = 16'h0000;
        run_sweep(0, 1'b0);
        check("restart_y", 0, 32'(yt_w[0]), 32'h0000);

        for (int r = 0; r < 6; r++) begin
            ymask = 16'($urandom);
            zmask = 16'($urandom);
            run_sweep(2, 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
